// File: rtl/crc_pkg.sv
// Shared constants and types for the CRC request path.
package crc_pkg;
  localparam int CRC_REQ_W_DEF       = 36;
  localparam int MAX_OUTSTANDING_DEF = 8;

  typedef logic [CRC_REQ_W_DEF-1:0] crc_req_t;
endpackage

// File: rtl/crc_rr_pick.sv
// Combinational round-robin picker: first set request at or after i_ptr, wrapping.
module crc_rr_pick #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  output logic [N-1:0]  o_gnt,
  output logic [IW-1:0] o_idx,
  output logic          o_any
);
  logic [IW-1:0] w_j;

  always_comb begin
    o_gnt = '0;
    o_idx = '0;
    o_any = 1'b0;
    w_j   = '0;
    for (int k = 0; k < N; k++) begin
      w_j = IW'((int'(i_ptr) + k) % N);
      if (!o_any && i_req[w_j]) begin
        o_any      = 1'b1;
        o_gnt[w_j] = 1'b1;
        o_idx      = w_j;
      end
    end
  end
endmodule

// File: rtl/crc_req_arb.sv
// Round-robin feeder for the CRC engine request channel with outstanding-request throttle.
module crc_req_arb #(
  parameter int N_SRC           = 4,
  parameter int CRC_REQ_WIDTH   = crc_pkg::CRC_REQ_W_DEF,
  parameter int MAX_OUTSTANDING = crc_pkg::MAX_OUTSTANDING_DEF,
  localparam int CNT_W          = $clog2(MAX_OUTSTANDING + 1),
  localparam int IW             = $clog2(N_SRC)
) (
  input  logic                           i_clk,
  input  logic                           i_nreset,
  input  logic                           i_arb_en,
  input  logic [N_SRC-1:0]               i_src_valid,
  input  logic [N_SRC*CRC_REQ_WIDTH-1:0] i_src_data,
  output logic [N_SRC-1:0]               o_src_ready,
  output logic                           o_crc_req_valid,
  output logic [CRC_REQ_WIDTH-1:0]       o_crc_req_data,
  input  logic                           i_crc_req_ready,
  input  logic                           i_crc_done_fire,
  output logic [IW-1:0]                  o_grant_id,
  output logic [CNT_W-1:0]               o_outstanding,
  output logic                           o_underflow
);
  logic                     r_valid;
  logic [CRC_REQ_WIDTH-1:0] r_data;
  logic [IW-1:0]            r_gid;
  logic [IW-1:0]            r_ptr;
  logic [CNT_W-1:0]         r_cnt;
  logic                     r_uf;

  logic [N_SRC-1:0] w_gnt;
  logic [IW-1:0]    w_idx;
  logic             w_any;
  logic             w_slot_free;
  logic             w_load;
  logic             w_dec;

  crc_rr_pick #(.N(N_SRC), .IW(IW)) u_pick (
    .i_req (i_src_valid),
    .i_ptr (r_ptr),
    .o_gnt (w_gnt),
    .o_idx (w_idx),
    .o_any (w_any)
  );

  assign w_slot_free = !r_valid || i_crc_req_ready;
  assign w_load      = i_arb_en && w_slot_free && (r_cnt < CNT_W'(MAX_OUTSTANDING)) && w_any;
  // A done at count 0 is ignored (flagged as underflow unless a load covers it).
  assign w_dec       = i_crc_done_fire && (r_cnt != '0);

  assign o_src_ready = (w_load && i_nreset) ? w_gnt : '0;

  always_ff @(posedge i_clk or negedge i_nreset) begin
    if (!i_nreset) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_gid   <= '0;
      r_ptr   <= '0;
      r_cnt   <= '0;
      r_uf    <= 1'b0;
    end else begin
      if (w_load) begin
        r_valid <= 1'b1;
        r_data  <= i_src_data[int'(w_idx)*CRC_REQ_WIDTH +: CRC_REQ_WIDTH];
        r_gid   <= w_idx;
        r_ptr   <= (int'(w_idx) == N_SRC-1) ? '0 : w_idx + IW'(1);
      end else if (i_crc_req_ready) begin
        r_valid <= 1'b0;
      end
      if (w_load && !w_dec)      r_cnt <= r_cnt + CNT_W'(1);
      else if (!w_load && w_dec) r_cnt <= r_cnt - CNT_W'(1);
      r_uf <= i_crc_done_fire && !w_load && (r_cnt == '0);
    end
  end

  assign o_crc_req_valid = r_valid;
  assign o_crc_req_data  = r_data;
  assign o_grant_id      = r_gid;
  assign o_outstanding   = r_cnt;
  assign o_underflow     = r_uf;
endmodule
